// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: dispatch, CDB, ALU-busy and issue bundle for the ALU issue queue.
interface alu_issue_queue_if #(
  parameter int TAG_W = 6,
  parameter int NUM_ALU = 3,
  parameter int CNT_W = 4
);
  logic flush;
  logic disp_valid;
  logic disp_ready;
  logic [3:0] disp_optype;
  logic [TAG_W-1:0] disp_dr;
  logic [TAG_W-1:0] disp_sr1_tag;
  logic [TAG_W-1:0] disp_sr2_tag;
  logic disp_sr1_rdy;
  logic disp_sr2_rdy;
  logic [31:0] disp_sr1_data;
  logic [31:0] disp_sr2_data;
  logic [31:0] disp_imm;
  logic [NUM_ALU-1:0] cdb_valid;
  logic [NUM_ALU*TAG_W-1:0] cdb_tag;
  logic [NUM_ALU*32-1:0] cdb_data;
  logic [NUM_ALU-1:0] alu_busy;
  logic issue_valid;
  logic [NUM_ALU-1:0] issue_alu_number;
  logic [3:0] issue_optype;
  logic [31:0] issue_sr1;
  logic [31:0] issue_sr2;
  logic [31:0] issue_imm;
  logic [TAG_W-1:0] issue_dr;
  logic [CNT_W-1:0] count;
  modport master (
    output flush, disp_valid, disp_optype, disp_dr, disp_sr1_tag, disp_sr2_tag,
           disp_sr1_rdy, disp_sr2_rdy, disp_sr1_data, disp_sr2_data, disp_imm,
           cdb_valid, cdb_tag, cdb_data, alu_busy,
    input  disp_ready, issue_valid, issue_alu_number, issue_optype,
           issue_sr1, issue_sr2, issue_imm, issue_dr, count
  );
  modport slave (
    input  flush, disp_valid, disp_optype, disp_dr, disp_sr1_tag, disp_sr2_tag,
           disp_sr1_rdy, disp_sr2_rdy, disp_sr1_data, disp_sr2_data, disp_imm,
           cdb_valid, cdb_tag, cdb_data, alu_busy,
    output disp_ready, issue_valid, issue_alu_number, issue_optype,
           issue_sr1, issue_sr2, issue_imm, issue_dr, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: compacting oldest-first issue queue with CDB wakeup feeding the ALU bank.
module alu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int NUM_ALU = 3
) (
  input logic clk,
  input logic rst,
  alu_issue_queue_if.slave io
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  typedef struct packed {
    logic v;
    logic [3:0] op;
    logic [TAG_W-1:0] dr;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic r1;
    logic r2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
  } ent_t;
  ent_t q [DEPTH];
  ent_t w [DEPTH+1];
  ent_t n [DEPTH];
  ent_t d;
  logic [CW-1:0] cnt;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0] sel;
  logic [NUM_ALU-1:0] alu_oh;
  logic do_iss;
  logic do_disp;
  logic iv;
  logic [NUM_ALU-1:0] ialu;
  logic [3:0] iop;
  logic [31:0] is1;
  logic [31:0] is2;
  logic [31:0] iimm;
  logic [TAG_W-1:0] idr;
  // Lanes scanned high to low so the lowest matching lane wins.
  function automatic logic [32:0] wake(input logic [TAG_W-1:0] t, input logic r, input logic [31:0] v);
    wake = {r, v};
    for (int i = NUM_ALU - 1; i >= 0; i--)
      if (!r && io.cdb_valid[i] && io.cdb_tag[i*TAG_W +: TAG_W] == t)
        wake = {1'b1, io.cdb_data[i*32 +: 32]};
  endfunction
  // LUI needs no source; single-source ops skip sr2.
  function automatic logic is_rdy(input ent_t e);
    logic need1;
    logic need2;
    need1 = e.op != 4'd3;
    need2 = !(e.op inside {4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8});
    is_rdy = e.v && (e.r1 || !need1) && (e.r2 || !need2);
  endfunction
  assign io.disp_ready = cnt != CW'(DEPTH);
  assign io.count = cnt;
  assign io.issue_valid = iv;
  assign io.issue_alu_number = ialu;
  assign io.issue_optype = iop;
  assign io.issue_sr1 = is1;
  assign io.issue_sr2 = is2;
  assign io.issue_imm = iimm;
  assign io.issue_dr = idr;
  always_comb begin
    rdy = '0;
    sel = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      rdy[j] = is_rdy(q[j]);
      if (rdy[j]) sel = IW'(j);
    end
    alu_oh = ~io.alu_busy & (io.alu_busy + NUM_ALU'(1));
    do_iss = |rdy && |alu_oh;
    do_disp = io.disp_valid && io.disp_ready;
    d.v = 1'b1;
    d.op = io.disp_optype;
    d.dr = io.disp_dr;
    d.t1 = io.disp_sr1_tag;
    d.t2 = io.disp_sr2_tag;
    d.imm = io.disp_imm;
    {d.r1, d.d1} = wake(io.disp_sr1_tag, io.disp_sr1_rdy, io.disp_sr1_data);
    {d.r2, d.d2} = wake(io.disp_sr2_tag, io.disp_sr2_rdy, io.disp_sr2_data);
    w[DEPTH] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w[j] = q[j];
      {w[j].r1, w[j].d1} = wake(q[j].t1, q[j].r1, q[j].d1);
      {w[j].r2, w[j].d2} = wake(q[j].t2, q[j].r2, q[j].d2);
    end
    for (int j = 0; j < DEPTH; j++)
      n[j] = (do_iss && IW'(j) >= sel) ? w[j+1] : w[j];
    if (do_disp) n[IW'(cnt - CW'(do_iss))] = d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '{default: '0};
      cnt <= '0;
      iv <= 1'b0;
      ialu <= '0;
      iop <= '0;
      is1 <= '0;
      is2 <= '0;
      iimm <= '0;
      idr <= '0;
    end else if (io.flush) begin
      q <= '{default: '0};
      cnt <= '0;
      iv <= 1'b0;
      ialu <= '0;
    end else begin
      q <= n;
      cnt <= cnt + CW'(do_disp) - CW'(do_iss);
      iv <= do_iss;
      ialu <= do_iss ? alu_oh : '0;
      if (do_iss) begin
        iop <= q[sel].op;
        is1 <= q[sel].d1;
        is2 <= q[sel].d2;
        iimm <= q[sel].imm;
        idr <= q[sel].dr;
      end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed checks of dispatch, wakeup, bypass, select, ALU choice and flush.
module tb_alu_issue_queue;
  logic clk;
  logic rst;
  int n_cmp;
  int n_bad;
  alu_issue_queue_if #(.TAG_W(6), .NUM_ALU(3), .CNT_W(4)) io ();
  alu_issue_queue #(.DEPTH(8), .TAG_W(6), .NUM_ALU(3)) dut (.clk(clk), .rst(rst), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic disp(input int op, input int dr, input int t1, input int r1, input int d1,
                      input int t2, input int r2, input int d2, input int imm);
    io.disp_valid = 1'b1;
    io.disp_optype = 4'(op);
    io.disp_dr = 6'(dr);
    io.disp_sr1_tag = 6'(t1);
    io.disp_sr1_rdy = 1'(r1);
    io.disp_sr1_data = 32'(d1);
    io.disp_sr2_tag = 6'(t2);
    io.disp_sr2_rdy = 1'(r2);
    io.disp_sr2_data = 32'(d2);
    io.disp_imm = 32'(imm);
  endtask
  task automatic idle();
    io.disp_valid = 1'b0;
    io.disp_optype = '0;
    io.disp_dr = '0;
    io.disp_sr1_tag = '0;
    io.disp_sr1_rdy = 1'b0;
    io.disp_sr1_data = '0;
    io.disp_sr2_tag = '0;
    io.disp_sr2_rdy = 1'b0;
    io.disp_sr2_data = '0;
    io.disp_imm = '0;
    io.cdb_valid = '0;
    io.cdb_tag = '0;
    io.cdb_data = '0;
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    io.flush = 1'b0;
    io.alu_busy = '0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_valid", io.issue_valid, 0);
    chk("rst_alu", io.issue_alu_number, 0);
    chk("rst_count", io.count, 0);
    chk("rst_ready", io.disp_ready, 1);
    chk("rst_sr1", io.issue_sr1, 0);
    rst = 1'b0;
    // ready ADD issues one cycle after dispatch
    disp(1, 5, 0, 1, 7, 0, 1, 9, 0);
    @(negedge clk);
    idle();
    chk("t1_count1", io.count, 1);
    chk("t1_early", io.issue_valid, 0);
    @(negedge clk);
    chk("t1_valid", io.issue_valid, 1);
    chk("t1_alu", io.issue_alu_number, 3'b001);
    chk("t1_sr1", io.issue_sr1, 7);
    chk("t1_sr2", io.issue_sr2, 9);
    chk("t1_dr", io.issue_dr, 5);
    chk("t1_count0", io.count, 0);
    @(negedge clk);
    chk("t1_drop", io.issue_valid, 0);
    chk("t1_alu0", io.issue_alu_number, 0);
    // ADDI waits for CDB lane 1
    disp(2, 6, 12, 0, 0, 13, 0, 0, 4);
    @(negedge clk);
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("t2_wait", io.issue_valid, 0);
      @(negedge clk);
    end
    io.cdb_valid = 3'b010;
    io.cdb_tag = {6'd0, 6'd12, 6'd0};
    io.cdb_data = {32'd0, 32'd100, 32'd0};
    @(negedge clk);
    idle();
    chk("t2_capture", io.issue_valid, 0);
    @(negedge clk);
    chk("t2_valid", io.issue_valid, 1);
    chk("t2_sr1", io.issue_sr1, 100);
    chk("t2_imm", io.issue_imm, 4);
    chk("t2_dr", io.issue_dr, 6);
    // dispatch bypass, lane 0 beats lane 2 on the same tag
    disp(1, 7, 20, 0, 0, 0, 1, 5, 0);
    io.cdb_valid = 3'b101;
    io.cdb_tag = {6'd20, 6'd0, 6'd20};
    io.cdb_data = {32'hCD, 32'd0, 32'hAB};
    @(negedge clk);
    idle();
    chk("t3_early", io.issue_valid, 0);
    @(negedge clk);
    chk("t3_valid", io.issue_valid, 1);
    chk("t3_sr1", io.issue_sr1, 32'hAB);
    chk("t3_sr2", io.issue_sr2, 5);
    chk("t3_dr", io.issue_dr, 7);
    // fill, overflow, wake middle then two out of order
    for (int k = 0; k < 8; k++) begin
      disp(1, 10 + k, 30 + k, 0, 0, 0, 1, 1, 0);
      @(negedge clk);
    end
    idle();
    chk("t4_full_count", io.count, 8);
    chk("t4_full_ready", io.disp_ready, 0);
    disp(1, 50, 50, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    idle();
    chk("t4_ovf_count", io.count, 8);
    io.cdb_valid = 3'b001;
    io.cdb_tag = {6'd0, 6'd0, 6'd33};
    io.cdb_data = {32'd0, 32'd0, 32'd333};
    @(negedge clk);
    idle();
    chk("t4_capture", io.issue_valid, 0);
    @(negedge clk);
    chk("t4_valid", io.issue_valid, 1);
    chk("t4_dr", io.issue_dr, 13);
    chk("t4_sr1", io.issue_sr1, 333);
    chk("t4_count", io.count, 7);
    chk("t4_ready", io.disp_ready, 1);
    io.cdb_valid = 3'b011;
    io.cdb_tag = {6'd0, 6'd30, 6'd34};
    io.cdb_data = {32'd0, 32'd300, 32'd334};
    @(negedge clk);
    idle();
    chk("t4_idle", io.issue_valid, 0);
    @(negedge clk);
    chk("t4_old_dr", io.issue_dr, 10);
    chk("t4_old_sr1", io.issue_sr1, 300);
    chk("t4_old_count", io.count, 6);
    @(negedge clk);
    chk("t4_next_dr", io.issue_dr, 14);
    chk("t4_next_sr1", io.issue_sr1, 334);
    chk("t4_next_count", io.count, 5);
    // flush with 5 entries and a concurrent ready dispatch
    disp(1, 60, 0, 1, 1, 0, 1, 1, 0);
    io.flush = 1'b1;
    @(negedge clk);
    io.flush = 1'b0;
    idle();
    chk("t6_count", io.count, 0);
    chk("t6_valid", io.issue_valid, 0);
    chk("t6_ready", io.disp_ready, 1);
    io.cdb_valid = 3'b111;
    io.cdb_tag = {6'd35, 6'd32, 6'd31};
    io.cdb_data = {32'd5, 32'd6, 32'd7};
    @(negedge clk);
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("t6_quiet", io.issue_valid, 0);
      @(negedge clk);
    end
    chk("t6_count_end", io.count, 0);
    // ALU selection, busy stall, issue concurrent with LUI dispatch
    io.alu_busy = 3'b111;
    disp(1, 21, 0, 1, 1, 0, 1, 2, 0);
    @(negedge clk);
    disp(1, 22, 0, 1, 3, 0, 1, 4, 0);
    @(negedge clk);
    idle();
    chk("t5_count2", io.count, 2);
    chk("t5_stall", io.issue_valid, 0);
    @(negedge clk);
    chk("t5_stall2", io.issue_valid, 0);
    chk("t5_stall_count", io.count, 2);
    io.alu_busy = 3'b011;
    disp(3, 23, 40, 0, 0, 41, 0, 0, 32'h5000);
    @(negedge clk);
    idle();
    io.alu_busy = 3'b111;
    chk("t5_valid", io.issue_valid, 1);
    chk("t5_alu", io.issue_alu_number, 3'b100);
    chk("t5_dr", io.issue_dr, 21);
    chk("t5_both_count", io.count, 2);
    @(negedge clk);
    chk("t5_busy_valid", io.issue_valid, 0);
    chk("t5_busy_alu", io.issue_alu_number, 0);
    chk("t5_busy_count", io.count, 2);
    io.alu_busy = 3'b000;
    @(negedge clk);
    chk("t5_b_dr", io.issue_dr, 22);
    chk("t5_b_alu", io.issue_alu_number, 3'b001);
    chk("t5_b_count", io.count, 1);
    @(negedge clk);
    chk("t5_lui_valid", io.issue_valid, 1);
    chk("t5_lui_dr", io.issue_dr, 23);
    chk("t5_lui_op", io.issue_optype, 3);
    chk("t5_lui_imm", io.issue_imm, 32'h5000);
    chk("t5_lui_count", io.count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
